// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer
//
// Purpose:
//   Conditions one raw, active-low push-button into a clean debounced level
//   plus single-cycle press and release strobes. The raw input is first
//   passed through a two-flop synchronizer. A four-state FSM then requires
//   DEBOUNCE_CYCLES consecutive stable synchronized samples before it
//   accepts a change of level.
//
// Optional feature:
//   KEY_REPEAT_EN - when defined, holding the key emits auto-repeat press
//   strobes. The first repeat comes REPEAT_DELAY cycles after the entry
//   strobe, and later repeats come every REPEAT_PERIOD cycles. When the
//   macro is undefined, HELD never strobes and no repeat logic is built.
//
// Ports:
//   clk           in   system clock (CLOCK_50 domain)
//   reset         in   asynchronous active-low reset
//   key_n         in   raw button, 0 = pressed, asynchronous to clk
//   pressed       out  debounced level, 1 = key held
//   press_pulse   out  one-cycle strobe on an accepted press (and repeats)
//   release_pulse out  one-cycle strobe on an accepted release
// ---------------------------------------------------------------------------
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  // The counter must be able to reach the largest terminal value of any
  // interval it times. It only ever counts up to (limit - 1).
  localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CNT = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nextCnt;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_pressed;
  logic             w_nextPressed;
  logic             r_pressPulse;
  logic             w_nextPressPulse;
  logic             r_releasePulse;
  logic             w_nextReleasePulse;
`ifdef KEY_REPEAT_EN
  // Distinguishes the initial repeat delay from the steady repeat period.
  logic             r_repeatPhase;
  logic             w_nextRepeatPhase;
`endif

  // Two-flop synchronizer on the asynchronous key input. Both flops reset
  // to the released level so that a key already held low when reset is
  // removed is seen as a fresh press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  // State, counter and registered outputs. Asserting reset clears the
  // outputs immediately in any state, and no strobe is emitted on reset exit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_pressed      <= 1'b0;
      r_pressPulse   <= 1'b0;
      r_releasePulse <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_repeatPhase  <= 1'b0;
`endif
    end else begin
      r_state        <= w_nextState;
      r_cnt          <= w_nextCnt;
      r_pressed      <= w_nextPressed;
      r_pressPulse   <= w_nextPressPulse;
      r_releasePulse <= w_nextReleasePulse;
`ifdef KEY_REPEAT_EN
      r_repeatPhase  <= w_nextRepeatPhase;
`endif
    end
  end

  // Next-state logic. The counter is reloaded on every state transition and
  // never wraps. Strobes default low so that each one lasts exactly one cycle.
  always_comb begin
    w_nextState        = r_state;
    w_nextCnt          = r_cnt;
    w_nextPressed      = r_pressed;
    w_nextPressPulse   = 1'b0;
    w_nextReleasePulse = 1'b0;
`ifdef KEY_REPEAT_EN
    w_nextRepeatPhase  = r_repeatPhase;
`endif

    case (r_state)
      IDLE: begin
        if (!r_sync2) begin
          w_nextState = PRESS_WAIT;
          w_nextCnt   = '0;
        end
      end

      PRESS_WAIT: begin
        if (r_sync2) begin
          // Bounce: give up silently.
          w_nextState = IDLE;
          w_nextCnt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_nextState      = HELD;
          w_nextCnt        = '0;
          w_nextPressed    = 1'b1;
          w_nextPressPulse = 1'b1;
`ifdef KEY_REPEAT_EN
          w_nextRepeatPhase = 1'b0;
`endif
        end else begin
          w_nextCnt = r_cnt + CNT_W'(1);
        end
      end

      HELD: begin
        if (r_sync2) begin
          w_nextState = RELEASE_WAIT;
          w_nextCnt   = '0;
`ifdef KEY_REPEAT_EN
          w_nextRepeatPhase = 1'b0;
`endif
        end else begin
`ifdef KEY_REPEAT_EN
          // Timing restarts at each repeat strobe. The first interval uses
          // REPEAT_DELAY, and all later intervals use REPEAT_PERIOD.
          if (!r_repeatPhase) begin
            if (r_cnt == RPT_DELAY_LAST) begin
              w_nextPressPulse  = 1'b1;
              w_nextCnt         = '0;
              w_nextRepeatPhase = 1'b1;
            end else begin
              w_nextCnt = r_cnt + CNT_W'(1);
            end
          end else begin
            if (r_cnt == RPT_PERIOD_LAST) begin
              w_nextPressPulse = 1'b1;
              w_nextCnt        = '0;
            end else begin
              w_nextCnt = r_cnt + CNT_W'(1);
            end
          end
`else
          w_nextCnt = r_cnt;
`endif
        end
      end

      RELEASE_WAIT: begin
        if (!r_sync2) begin
          // Bounce during release: the key is still held, with no strobe.
          w_nextState = HELD;
          w_nextCnt   = '0;
`ifdef KEY_REPEAT_EN
          w_nextRepeatPhase = 1'b0;
`endif
        end else if (r_cnt == DB_LAST) begin
          w_nextState        = IDLE;
          w_nextCnt          = '0;
          w_nextPressed      = 1'b0;
          w_nextReleasePulse = 1'b1;
        end else begin
          w_nextCnt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_nextState = IDLE;
        w_nextCnt   = '0;
      end
    endcase
  end

  assign pressed       = r_pressed;
  assign press_pulse   = r_pressPulse;
  assign release_pulse = r_releasePulse;

endmodule

// File: tb/tb_key_debouncer.sv
// ---------------------------------------------------------------------------
// tb_key_debouncer
//
// Purpose:
//   Self-checking bench for key_debouncer with DEBOUNCE_CYCLES=8,
//   REPEAT_DELAY=20 and REPEAT_PERIOD=10. A run-length model predicts the
//   outputs, and these are compared with the DUT on every falling clock
//   edge. Directed scenarios add hand-computed checks on strobe counts and
//   strobe edges. The expectations follow KEY_REPEAT_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_key_debouncer;

  localparam int DB  = 8;
  localparam int RD  = 20;
  localparam int RP  = 10;
  localparam int LAT = DB + 2;

  logic clk = 1'b0;
  logic reset;
  logic key_n;
  logic pressed;
  logic press_pulse;
  logic release_pulse;

  int checks   = 0;
  int failures = 0;
  int edgeNum  = 0;

  int dutPressCount   = 0;
  int dutReleaseCount = 0;
  int dutPressEdge    = -1;
  int dutReleaseEdge  = -1;
  int modelPressEdge  = -1;

  // Model state: synchronizer history, the current run of samples that
  // disagree with the debounced level, and the time since entering HELD.
  logic mSync1    = 1'b1;
  logic mSync2    = 1'b1;
  logic mPressed  = 1'b0;
  logic mPressP   = 1'b0;
  logic mReleaseP = 1'b0;
  int   runLen    = 0;
  int   heldAge   = -1;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_n(key_n),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeNum = edgeNum + 1;

  // Behavioural model. A level change is accepted once DB+1 consecutive
  // synchronized samples disagree with the current debounced level. The
  // first of these samples is the one seen while idle or held.
  always @(posedge clk or negedge reset) begin
    logic s;
    if (!reset) begin
      mSync1 = 1'b1; mSync2 = 1'b1;
      mPressed = 1'b0; mPressP = 1'b0; mReleaseP = 1'b0;
      runLen = 0; heldAge = -1;
    end else begin
      s = mSync2;
      mSync2 = mSync1;
      mSync1 = key_n;
      mPressP = 1'b0;
      mReleaseP = 1'b0;
      if ((s == 1'b0) != mPressed) begin
        runLen = runLen + 1;
        if (runLen == DB + 1) begin
          mPressed = ~mPressed;
          runLen = 0;
          if (mPressed) begin
            mPressP = 1'b1;
            heldAge = 0;
          end else begin
            mReleaseP = 1'b1;
          end
        end else if (mPressed) begin
          heldAge = -1;
        end
      end else begin
        runLen = 0;
        if (mPressed) begin
          if (heldAge < 0) heldAge = 0;
          else begin
            heldAge = heldAge + 1;
`ifdef KEY_REPEAT_EN
            if (heldAge == RD || (heldAge > RD && (heldAge - RD) % RP == 0))
              mPressP = 1'b1;
`endif
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus strobe bookkeeping.
  always @(negedge clk) begin
    checkOutput("cyc_pressed", int'(pressed), int'(mPressed));
    checkOutput("cyc_press_pulse", int'(press_pulse), int'(mPressP));
    checkOutput("cyc_release_pulse", int'(release_pulse), int'(mReleaseP));
    if (press_pulse === 1'b1) begin
      dutPressCount = dutPressCount + 1;
      dutPressEdge  = edgeNum;
    end
    if (release_pulse === 1'b1) begin
      dutReleaseCount = dutReleaseCount + 1;
      dutReleaseEdge  = edgeNum;
    end
    if (mPressP) modelPressEdge = edgeNum;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic k, input int cycles);
    key_n = k;
    waitCycles(cycles);
  endtask

  initial begin
    int base;
    int p0;
    int r0;
    reset = 1'b0;
    key_n = 1'b1;

    // Reset held while the key toggles: outputs stay low.
    for (int i = 0; i < 6; i++) applyStimulus(i[0], 1);
    checkOutput("reset_pressed", int'(pressed), 0);
    checkOutput("reset_press_pulse", int'(press_pulse), 0);
    key_n = 1'b1;
    reset = 1'b1;
    waitCycles(20);
    checkOutput("post_reset_pressed", int'(pressed), 0);
    checkOutput("post_reset_no_strobes", dutPressCount + dutReleaseCount, 0);

    // Clean press: strobe after edge E0+DB+2.
    p0 = dutPressCount;
    base = edgeNum + 1;
    applyStimulus(1'b0, 20);
    checkOutput("press_count", dutPressCount - p0, 1);
    checkOutput("press_edge", dutPressEdge - base, LAT);
    checkOutput("model_press_edge", modelPressEdge - base, LAT);
    checkOutput("press_level", int'(pressed), 1);

    // Release glitch: high 5, low 4, then held low. The key stays pressed.
    r0 = dutReleaseCount;
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 4);
    applyStimulus(1'b0, 14);
    checkOutput("glitch_release_count", dutReleaseCount - r0, 0);
    checkOutput("glitch_pressed", int'(pressed), 1);

    // Clean release.
    base = edgeNum + 1;
    applyStimulus(1'b1, 20);
    checkOutput("release_count", dutReleaseCount - r0, 1);
    checkOutput("release_edge", dutReleaseEdge - base, LAT);
    checkOutput("release_level", int'(pressed), 0);

    // Bounce: low 5 and high 3, four times, then released.
    p0 = dutPressCount;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 5);
      applyStimulus(1'b1, 3);
    end
    applyStimulus(1'b1, 20);
    checkOutput("bounce_press_count", dutPressCount - p0, 0);
    checkOutput("bounce_pressed", int'(pressed), 0);

    // Reset asserted in PRESS_WAIT with cnt=5, then released with the key low.
    applyStimulus(1'b0, 8);
    #1 reset = 1'b0;
    #1;
    checkOutput("midpw_reset_pressed", int'(pressed), 0);
    checkOutput("midpw_reset_press_pulse", int'(press_pulse), 0);
    waitCycles(3);
    p0 = dutPressCount;
    base = edgeNum + 1;
    reset = 1'b1;
    waitCycles(15);
    checkOutput("fresh_press_count", dutPressCount - p0, 1);
    checkOutput("fresh_press_edge", dutPressEdge - base, LAT);

    // Reset asserted while HELD clears pressed asynchronously.
    checkOutput("held_before_reset", int'(pressed), 1);
    #1 reset = 1'b0;
    #1;
    checkOutput("held_reset_pressed", int'(pressed), 0);
    key_n = 1'b1;
    waitCycles(2);
    p0 = dutPressCount;
    r0 = dutReleaseCount;
    reset = 1'b1;
    waitCycles(20);
    checkOutput("held_reset_exit_strobes", (dutPressCount - p0) + (dutReleaseCount - r0), 0);

    // Long hold for 55 cycles past the entry strobe, then release.
    p0 = dutPressCount;
    r0 = dutReleaseCount;
    base = edgeNum + 1;
    applyStimulus(1'b0, LAT + 56);
    applyStimulus(1'b1, 25);
    checkOutput("hold_release_count", dutReleaseCount - r0, 1);
`ifdef KEY_REPEAT_EN
    checkOutput("hold_press_count", dutPressCount - p0, 5);
    checkOutput("hold_last_repeat_edge", dutPressEdge - base, LAT + 50);
`else
    checkOutput("hold_press_count", dutPressCount - p0, 1);
    checkOutput("hold_last_press_edge", dutPressEdge - base, LAT);
`endif
    checkOutput("hold_final_pressed", int'(pressed), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
